// File: rtl/csr_register_file.sv
// Machine-mode CSR storage with 64-bit cycle/instret counters.
// Serves one read-modify-write request at a time over valid/ready handshakes.
// Each response returns the CSR value from before the write.
module csr_register_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h40000100,
  parameter logic [31:0] MTVEC_RESET = 32'h00000000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic        instret_inc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic        accept;
  logic        rd_hit;
  logic [31:0] rd_val;
  logic        ro_space;
  logic        acc_error;
  logic        wr_en;

  // Address decode: value currently held at req_addr, and whether it is mapped.
  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (req_addr)
      12'hF14:          rd_val = HART_ID;
      12'h301:          rd_val = MISA_VALUE;
      12'h340:          rd_val = mscratch_q;
      12'h305:          rd_val = mtvec_q;
      12'hB00, 12'hC00: rd_val = mcycle_q[31:0];
      12'hB80, 12'hC80: rd_val = mcycle_q[63:32];
      12'hB02, 12'hC02: rd_val = minstret_q[31:0];
      12'hB82, 12'hC82: rd_val = minstret_q[63:32];
      default:          rd_hit = 1'b0;
    endcase
  end

  // addr[11:10] == 2'b11 is the read-only CSR space; misa writes are silently ignored
  assign ro_space  = (req_addr[11:10] == 2'b11);
  assign acc_error = !rd_hit || (req_write && ro_space);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_write && !acc_error;

  // CSR and counter next state; a counter write replaces that cycle's increment.
  always_comb begin
    mscratch_d = mscratch_q;
    mtvec_d    = mtvec_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instret_inc};
    if (wr_en) begin
      case (req_addr)
        12'h340: mscratch_d = req_wdata;
        12'h305: mtvec_d    = {req_wdata[31:2], 2'b00};
        12'hB00: mcycle_d   = {mcycle_q[63:32], req_wdata};
        12'hB80: mcycle_d   = {req_wdata, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], req_wdata};
        12'hB82: minstret_d = {req_wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // Response capture on the accept edge; held until the response is taken.
  always_comb begin
    rdata_d = rdata_q;
    error_d = error_q;
    if (accept) begin
      rdata_d = acc_error ? 32'd0 : rd_val;
      error_d = acc_error;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; req_ready is also held low while reset is asserted.
  always_comb begin
    req_ready = (state_q == StIdle) && reset;
    rsp_valid = (state_q == StResp);
    rsp_rdata = rdata_q;
    rsp_error = error_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= StIdle;
      mscratch_q <= '0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mcycle_q   <= '0;
      minstret_q <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mscratch_q <= mscratch_d;
      mtvec_q    <= mtvec_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_csr_register_file.sv
// Self-checking bench for csr_register_file: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_csr_register_file;

  localparam logic [31:0] HART_ID     = 32'd3;
  localparam logic [31:0] MISA_VALUE  = 32'h40000100;
  localparam logic [31:0] MTVEC_RESET = 32'h00001003;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        instret_inc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  bit          m_busy;
  logic [63:0] m_cyc, m_inst;
  logic [31:0] m_scr, m_tvec, e_rdata;
  bit          e_err;

  csr_register_file #(
    .HART_ID    (HART_ID),
    .MISA_VALUE (MISA_VALUE),
    .MTVEC_RESET(MTVEC_RESET)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .instret_inc(instret_inc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {mapped, value} of a CSR in the model
  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'hF14:          return {1'b1, HART_ID};
      12'h301:          return {1'b1, MISA_VALUE};
      12'h340:          return {1'b1, m_scr};
      12'h305:          return {1'b1, m_tvec};
      12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b1, m_inst[31:0]};
      12'hB82, 12'hC82: return {1'b1, m_inst[63:32]};
      default:          return 33'd0;
    endcase
  endfunction

  // Advance one clock: predict the edge from current inputs, then compare outputs.
  task automatic tick();
    logic [32:0] rd;
    bit          acc, err;
    logic [63:0] n_cyc, n_inst;
    logic [31:0] n_scr, n_tvec, n_rdata;
    bit          n_busy, n_err;
    n_cyc = m_cyc; n_inst = m_inst; n_scr = m_scr; n_tvec = m_tvec;
    n_busy = m_busy; n_rdata = e_rdata; n_err = e_err;
    if (!reset) begin
      n_busy = 0; n_cyc = 0; n_inst = 0; n_scr = 0;
      n_tvec = MTVEC_RESET & ~32'd3; n_rdata = 0; n_err = 0;
    end else begin
      n_cyc  = m_cyc + 64'd1;
      n_inst = m_inst + (instret_inc ? 64'd1 : 64'd0);
      acc    = req_valid && !m_busy;
      if (m_busy && rsp_ready) n_busy = 0;
      if (acc) begin
        rd      = m_read(req_addr);
        err     = !rd[32] || (req_write && req_addr[11:10] == 2'b11);
        n_busy  = 1;
        n_err   = err;
        n_rdata = err ? 32'd0 : rd[31:0];
        if (req_write && !err) begin
          case (req_addr)
            12'h340: n_scr  = req_wdata;
            12'h305: n_tvec = req_wdata & ~32'd3;
            12'hB00: n_cyc  = (m_cyc & 64'hFFFFFFFF_00000000) | 64'(req_wdata);
            12'hB80: n_cyc  = (m_cyc & 64'h00000000_FFFFFFFF) | (64'(req_wdata) << 32);
            12'hB02: n_inst = (m_inst & 64'hFFFFFFFF_00000000) | 64'(req_wdata);
            12'hB82: n_inst = (m_inst & 64'h00000000_FFFFFFFF) | (64'(req_wdata) << 32);
            default: ;
          endcase
        end
      end
    end
    @(posedge CLK);
    m_cyc = n_cyc; m_inst = n_inst; m_scr = n_scr; m_tvec = n_tvec;
    m_busy = n_busy; e_rdata = n_rdata; e_err = n_err;
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(m_busy));
    check("req_ready", 64'(req_ready), 64'(reset && !m_busy));
    if (m_busy) begin
      check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
      check("rsp_error", 64'(rsp_error), 64'(e_err));
    end
  endtask

  // One complete transaction: wait for accept (bounded), capture response, take it.
  task automatic access(input logic [11:0] a, input bit w, input logic [31:0] d,
                        output logic [31:0] rdata_o, output bit err_o);
    int n = 0;
    req_valid = 1; req_addr = a; req_write = w; req_wdata = d; rsp_ready = 0;
    do begin
      tick();
      n++;
    end while (!m_busy && n < 20);
    if (!m_busy) check("accept_timeout", 64'd0, 64'd1);
    req_valid = 0;
    rdata_o = rsp_rdata;
    err_o   = rsp_error;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  logic [11:0] addrs [14] = '{12'hF14, 12'h301, 12'h340, 12'h305, 12'hB00, 12'hB80,
                              12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                              12'h7FF, 12'h000};

  initial begin
    logic [31:0] r;
    bit          e;
    reset = 0; req_valid = 0; req_addr = 0; req_write = 0; req_wdata = 0;
    instret_inc = 0; rsp_ready = 0;
    m_busy = 0; m_cyc = 0; m_inst = 0; m_scr = 0; m_tvec = 0; e_rdata = 0; e_err = 0;
    repeat (3) tick();
    check("reset_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1;

    // hartid read; req_ready low while the response is pending
    req_valid = 1; req_addr = 12'hF14; req_write = 0;
    tick();
    check("hartid_data", 64'(rsp_rdata), 64'd3);
    check("hartid_busy", 64'(req_ready), 64'd0);
    req_valid = 0; rsp_ready = 1; tick(); rsp_ready = 0;

    // mscratch write then read back
    access(12'h340, 1, 32'hDEADBEEF, r, e);
    check("mscratch_old", 64'(r), 64'd0);
    access(12'h340, 0, 32'h0, r, e);
    check("mscratch_new", 64'(r), 64'hDEADBEEF);

    // mtvec low bits dropped
    access(12'h305, 1, 32'h12345677, r, e);
    check("mtvec_reset", 64'(r), 64'h00001000);
    access(12'h305, 0, 32'h0, r, e);
    check("mtvec_align", 64'(r), 64'h12345674);

    // backpressure: response held, new requests ignored
    req_valid = 1; req_addr = 12'h301; req_write = 0;
    tick();
    req_addr = 12'h340; req_write = 1; req_wdata = 32'h11111111;
    repeat (5) tick();
    check("bp_hold", 64'(rsp_rdata), 64'(MISA_VALUE));
    req_valid = 0; rsp_ready = 1; tick(); rsp_ready = 0;
    access(12'h340, 0, 32'h0, r, e);
    check("bp_nowrite", 64'(r), 64'hDEADBEEF);

    // mcycle wrap through the 64-bit boundary
    access(12'hB80, 1, 32'hFFFFFFFF, r, e);
    access(12'hB00, 1, 32'hFFFFFFFF, r, e);
    tick(); tick();
    access(12'hB80, 0, 32'h0, r, e);
    check("mcycle_wrap", 64'(r), 64'd0);
    access(12'hB00, 0, 32'h0, r, e);

    // error cases and misa write-ignore
    access(12'hC00, 1, 32'h55555555, r, e);
    check("ro_err", 64'(e), 64'd1);
    check("ro_data", 64'(r), 64'd0);
    access(12'h7FF, 0, 32'h0, r, e);
    check("unmapped_err", 64'(e), 64'd1);
    access(12'h301, 1, 32'h0, r, e);
    check("misa_werr", 64'(e), 64'd0);
    access(12'h301, 0, 32'h0, r, e);
    check("misa_keep", 64'(r), 64'(MISA_VALUE));
    access(12'hF14, 1, 32'h9, r, e);
    check("hartid_werr", 64'(e), 64'd1);

    // reset while a response is pending, then count four retirements
    req_valid = 1; req_addr = 12'h340; req_write = 0;
    tick();
    req_valid = 0; reset = 0;
    tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1;
    instret_inc = 1; repeat (4) tick(); instret_inc = 0;
    access(12'hB02, 0, 32'h0, r, e);
    check("minstret4", 64'(r), 64'd4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid   = ($urandom_range(0, 2) != 0);
      req_addr    = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 13)];
      req_write   = $urandom_range(0, 1) == 1;
      req_wdata   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      instret_inc = $urandom_range(0, 1) == 1;
      rsp_ready   = ($urandom_range(0, 9) < 7);
      reset       = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1; req_valid = 0; rsp_ready = 1; instret_inc = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
